bios_loader: RTL and testbench

Sequences the BIOS image from the HPS `ioctl` download channel into the Next186 `system` BIOS write port (`BIOS_ADDR`/`BIOS_DIN`/`BIOS_WR`/`BIOS_REQ`). It packs bytes into 16-bit little-endian words and buffers them in a small FIFO, throttling the HPS with `ioctl_wait`. It delivers words in strict address order and produces `bios_loaded` and a core reset hold. It sits in `emu` between `hps_io` and `system`, replacing the ad-hoc loader process.

---
 rtl/bios_loader.sv | 255 +++++++++++++++++++++++++
 tb/tb_bios_loader.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_loader.sv
// Streams the BIOS image from the HPS ioctl byte channel into the Next186 BIOS write port.
// Bytes are packed little-endian into words, buffered in a small FIFO and released in address order.
module bios_loader #(
   parameter int         WORDS      = 8192,
   parameter int         AW         = 13,
   parameter logic [7:0] INDEX      = 8'h00,
   parameter int         FIFO_DEPTH = 4,
   parameter int         RST_HOLD   = 16
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          ioctl_download,
   input  logic          ioctl_wr,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   input  logic [7:0]    ioctl_index,
   output logic          ioctl_wait,
   output logic [AW-1:0] bios_addr,
   output logic [15:0]   bios_din,
   output logic          bios_wr,
   input  logic          bios_req,
   output logic          bios_loaded,
   output logic          core_reset,
   output logic          overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int HW = $clog2(RST_HOLD + 1) + 1;
   localparam logic [24:0]   BYTE_LIMIT = 25'(2 * WORDS);
   localparam logic [CW-1:0] WAIT_HI    = CW'(FIFO_DEPTH - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            dl_q, dl_d;
   logic [7:0]      latch_q, latch_d;
   logic            latch_vld_q, latch_vld_d;
   logic [15:0]     mem_q [FIFO_DEPTH];
   logic [15:0]     mem_d [FIFO_DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [15:0]     din_q, din_d;
   logic            wr_q, wr_d;
   logic            wait_q, wait_d;
   logic            loaded_q, loaded_d;
   logic            core_rst_q, core_rst_d;
   logic            ovf_q, ovf_d;
   logic            popped_q, popped_d;
   logic [HW-1:0]   hold_q, hold_d;

   logic            dl_acc, rise, fall, clear, take_byte, push, pop;
   logic [15:0]     push_word;
   logic [7:0]      latch_base;
   logic [PW-1:0]   rd_base, wr_base;
   logic [CW-1:0]   cnt_base, remain;

   // Next-state computation for the sequencer, byte packer and word FIFO.
   always_comb begin
      dl_acc      = ioctl_download && (ioctl_index == INDEX);
      rise        = dl_acc && !dl_q;
      fall        = !dl_acc && dl_q;
      state_d     = state_q;
      dl_d        = dl_acc;
      latch_d     = latch_q;
      latch_vld_d = latch_vld_q;
      mem_d       = mem_q;
      addr_d      = addr_q;
      ovf_d       = ovf_q;
      popped_d    = popped_q;
      hold_d      = hold_q;
      loaded_d    = loaded_q;
      core_rst_d  = core_rst_q;
      clear       = 1'b0;
      take_byte   = 1'b0;
      push        = 1'b0;
      push_word   = 16'h0000;

      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d   = LOAD;
               clear     = 1'b1;
               take_byte = ioctl_wr;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (fall) begin
               state_d     = DRAIN;
               latch_d     = 8'h00;
               latch_vld_d = 1'b0;
               if (latch_vld_q) begin
                  push      = 1'b1;
                  push_word = {8'h00, latch_q};
               end else begin
                  push = 1'b0;
               end
            end else begin
               take_byte = ioctl_wr && dl_acc;
            end
         end
         DRAIN: begin
            if (count_q == {CW{1'b0}}) begin
               state_d = popped_q ? DONE : IDLE;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE: begin
            if (rise) begin
               state_d   = LOAD;
               clear     = 1'b1;
               take_byte = ioctl_wr;
            end else begin
               loaded_d = 1'b1;
               // Hold counting starts on the first cycle bios_loaded is visible.
               if (loaded_q && (hold_q >= HOLD_LAST)) begin
                  core_rst_d = 1'b0;
               end else if (loaded_q) begin
                  hold_d = hold_q + HW'(1);
               end else begin
                  hold_d = hold_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (clear) begin
         latch_d     = 8'h00;
         latch_vld_d = 1'b0;
         addr_d      = {AW{1'b0}};
         ovf_d       = 1'b0;
         popped_d    = 1'b0;
         hold_d      = {HW{1'b0}};
         loaded_d    = 1'b0;
         core_rst_d  = 1'b1;
      end else begin
         popped_d = popped_q;
      end

      latch_base = clear ? 8'h00 : latch_q;
      if (take_byte) begin
         if (ioctl_addr >= BYTE_LIMIT) begin
            ovf_d = 1'b1;
         end else if (!ioctl_addr[0]) begin
            latch_d     = ioctl_dout;
            latch_vld_d = 1'b1;
         end else begin
            push        = 1'b1;
            push_word   = {ioctl_dout, latch_base};
            latch_d     = 8'h00;
            latch_vld_d = 1'b0;
         end
      end else begin
         latch_base = latch_base;
      end

      rd_base  = clear ? {PW{1'b0}} : rd_ptr_q;
      wr_base  = clear ? {PW{1'b0}} : wr_ptr_q;
      cnt_base = clear ? {CW{1'b0}} : count_q;
      pop      = bios_req && wr_q && ((state_q == LOAD) || (state_q == DRAIN));

      if (pop) begin
         rd_ptr_d = rd_base + PW'(1);
         addr_d   = addr_q + AW'(1);
         popped_d = 1'b1;
      end else begin
         rd_ptr_d = rd_base;
      end

      if (push) begin
         mem_d[wr_base] = push_word;
         wr_ptr_d       = wr_base + PW'(1);
      end else begin
         wr_ptr_d = wr_base;
      end

      remain  = cnt_base - CW'(pop);
      count_d = remain + CW'(push);

      // A word pushed into an empty FIFO bypasses the array so it is visible next cycle.
      if (push && (remain == {CW{1'b0}})) begin
         din_d = push_word;
      end else if (remain != {CW{1'b0}}) begin
         din_d = mem_q[rd_ptr_d];
      end else begin
         din_d = 16'h0000;
      end

      wr_d   = (count_d != {CW{1'b0}});
      wait_d = (count_d >= WAIT_HI);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         dl_q        <= 1'b0;
         latch_q     <= 8'h00;
         latch_vld_q <= 1'b0;
         mem_q       <= '{default: 16'h0000};
         rd_ptr_q    <= {PW{1'b0}};
         wr_ptr_q    <= {PW{1'b0}};
         count_q     <= {CW{1'b0}};
         addr_q      <= {AW{1'b0}};
         din_q       <= 16'h0000;
         wr_q        <= 1'b0;
         wait_q      <= 1'b0;
         loaded_q    <= 1'b0;
         core_rst_q  <= 1'b1;
         ovf_q       <= 1'b0;
         popped_q    <= 1'b0;
         hold_q      <= {HW{1'b0}};
      end else begin
         state_q     <= state_d;
         dl_q        <= dl_d;
         latch_q     <= latch_d;
         latch_vld_q <= latch_vld_d;
         mem_q       <= mem_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         wr_q        <= wr_d;
         wait_q      <= wait_d;
         loaded_q    <= loaded_d;
         core_rst_q  <= core_rst_d;
         ovf_q       <= ovf_d;
         popped_q    <= popped_d;
         hold_q      <= hold_d;
      end
   end

   assign ioctl_wait  = wait_q;
   assign bios_addr   = addr_q;
   assign bios_din    = din_q;
   assign bios_wr     = wr_q;
   assign bios_loaded = loaded_q;
   assign core_reset  = core_rst_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_bios_loader.sv
// Bench for bios_loader: a byte-stream HPS model and a randomly stalling system model,
// with expected words computed directly from the byte image.
module tb_bios_loader;

   localparam int         WORDS = 256;
   localparam int         AW    = 8;
   localparam int         DEPTH = 4;
   localparam int         HOLD  = 16;
   localparam logic [7:0] IDX   = 8'h00;

   logic          clk_sys = 1'b0;
   logic          reset_n = 1'b0;
   logic          ioctl_download = 1'b0;
   logic          ioctl_wr = 1'b0;
   logic [24:0]   ioctl_addr = 25'd0;
   logic [7:0]    ioctl_dout = 8'h00;
   logic [7:0]    ioctl_index = 8'h00;
   logic          ioctl_wait;
   logic [AW-1:0] bios_addr;
   logic [15:0]   bios_din;
   logic          bios_wr;
   logic          bios_req;
   logic          bios_loaded;
   logic          core_reset;
   logic          overflow;

   int total = 0;
   int bad   = 0;

   logic [7:0]    img[$];
   logic [15:0]   exp_w[$];
   logic [15:0]   cap_din[$];
   logic [AW-1:0] cap_addr[$];
   bit            req_en   = 1'b0;
   bit            req_junk = 1'b0;
   int            req_pct  = 100;
   bit            abort_tx = 1'b0;
   int            pushed   = 0;

   bios_loader #(
      .WORDS(WORDS), .AW(AW), .INDEX(IDX), .FIFO_DEPTH(DEPTH), .RST_HOLD(HOLD)
   ) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
      .bios_addr(bios_addr), .bios_din(bios_din), .bios_wr(bios_wr), .bios_req(bios_req),
      .bios_loaded(bios_loaded), .core_reset(core_reset), .overflow(overflow)
   );

   always #5 clk_sys = ~clk_sys;

   // System model: acknowledges held words (randomly delayed) and records what it consumed.
   initial begin
      bios_req = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (req_en && bios_wr === 1'b1 && $urandom_range(99) < req_pct) begin
            bios_req = 1'b1;
            cap_din.push_back(bios_din);
            cap_addr.push_back(bios_addr);
         end else if (req_junk && bios_wr === 1'b0) begin
            bios_req = 1'($urandom_range(1));
         end else begin
            bios_req = 1'b0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1);
   end

   // Reference: little-endian pairing, bytes past 2*WORDS dropped, odd tail zero-padded.
   function automatic void build_expected();
      int nb;
      logic [7:0] lo, hi;
      exp_w.delete();
      nb = (img.size() < 2 * WORDS) ? img.size() : 2 * WORDS;
      for (int k = 0; 2 * k < nb; k++) begin
         lo = img[2 * k];
         hi = (2 * k + 1 < nb) ? img[2 * k + 1] : 8'h00;
         exp_w.push_back({hi, lo});
      end
   endfunction

   task automatic apply_reset();
      req_en = 1'b0;
      ioctl_download = 1'b0;
      ioctl_wr = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);
   endtask

   // HPS model: one byte per strobe, honouring ioctl_wait; first strobe rides the rising edge.
   task automatic send_image(input logic [7:0] idx, input int gap_max);
      int i = 0;
      int guard;
      pushed = 0;
      @(negedge clk_sys);
      ioctl_index = idx;
      ioctl_download = 1'b1;
      while (i < img.size() && !abort_tx) begin
         guard = 0;
         while (ioctl_wait === 1'b1 && guard < 2000) begin
            @(negedge clk_sys);
            guard++;
         end
         if (guard >= 2000) begin
            total++;
            bad++;
            $display("FAIL hps_wait: ioctl_wait stuck at %b, required release", ioctl_wait);
            break;
         end
         ioctl_wr = 1'b1;
         ioctl_addr = 25'(i);
         ioctl_dout = img[i];
         if (i[0] && i < 2 * WORDS) pushed++;
         i++;
         @(negedge clk_sys);
         ioctl_wr = 1'b0;
         repeat ($urandom_range(gap_max)) @(negedge clk_sys);
      end
      if (!abort_tx && (img.size() % 2 == 1) && (img.size() - 1 < 2 * WORDS)) pushed++;
      ioctl_download = 1'b0;
      ioctl_wr = 1'b0;
   endtask

   task automatic wait_loaded(input int budget, output bit ok);
      int c = 0;
      while (bios_loaded !== 1'b1 && c < budget) begin
         @(negedge clk_sys);
         c++;
      end
      ok = (bios_loaded === 1'b1);
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL rst_wait: got %b need 0", ioctl_wait); end
      total++; if (bios_addr !== '0) begin bad++; $display("FAIL rst_addr: got %h need 0", bios_addr); end
      total++; if (bios_din !== 16'h0000) begin bad++; $display("FAIL rst_din: got %h need 0000", bios_din); end
      total++; if (bios_wr !== 1'b0) begin bad++; $display("FAIL rst_wr: got %b need 0", bios_wr); end
      total++; if (bios_loaded !== 1'b0) begin bad++; $display("FAIL rst_loaded: got %b need 0", bios_loaded); end
      total++; if (core_reset !== 1'b1) begin bad++; $display("FAIL rst_core_reset: got %b need 1", core_reset); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b need 0", overflow); end
   endtask

   task automatic test_full_load();
      bit ok;
      int c = 0;
      apply_reset();
      img.delete();
      for (int i = 0; i < 2 * WORDS; i++) img.push_back(8'(i));
      build_expected();
      cap_din.delete(); cap_addr.delete();
      req_en = 1'b1; req_pct = 100; req_junk = 1'b0;
      send_image(IDX, 0);
      wait_loaded(5000, ok);
      total++; if (!ok) begin bad++; $display("FAIL full_loaded: got %b need 1", bios_loaded); end
      total++; if (core_reset !== 1'b1) begin bad++; $display("FAIL full_reset_at_load: got %b need 1", core_reset); end
      while (core_reset === 1'b1 && c < 100) begin
         @(negedge clk_sys);
         c++;
      end
      total++; if (c != HOLD) begin bad++; $display("FAIL full_reset_hold: got %0d cycles need %0d", c, HOLD); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_overflow: got %b need 0", overflow); end
      total++; if (bios_addr !== '0) begin bad++; $display("FAIL full_addr_wrap: got %h need 0", bios_addr); end
      total++; if (cap_din.size() != exp_w.size()) begin bad++; $display("FAIL full_count: got %0d need %0d", cap_din.size(), exp_w.size()); end
      for (int k = 0; k < cap_din.size() && k < exp_w.size(); k++) begin
         total++;
         if (cap_din[k] !== exp_w[k] || cap_addr[k] !== AW'(k)) begin
            bad++;
            $display("FAIL full_word[%0d]: got %h@%h need %h@%h", k, cap_din[k], cap_addr[k], exp_w[k], AW'(k));
         end
      end
   endtask

   task automatic test_stall();
      bit ok;
      img.delete();
      for (int i = 0; i < 80; i++) img.push_back(8'($urandom));
      build_expected();
      cap_din.delete(); cap_addr.delete();
      req_en = 1'b1; req_pct = 70; req_junk = 1'b1;
      fork
         send_image(IDX, 1);
         begin
            repeat (20) @(negedge clk_sys);
            req_en = 1'b0;
            repeat (200) @(negedge clk_sys);
            total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL stall_wait: got %b need 1", ioctl_wait); end
            total++;
            if (pushed - cap_din.size() != DEPTH - 1) begin
               bad++;
               $display("FAIL stall_occupancy: got %0d need %0d", pushed - cap_din.size(), DEPTH - 1);
            end
            req_en = 1'b1;
         end
      join
      wait_loaded(5000, ok);
      total++; if (!ok) begin bad++; $display("FAIL stall_loaded: got %b need 1", bios_loaded); end
      total++; if (cap_din.size() != exp_w.size()) begin bad++; $display("FAIL stall_count: got %0d need %0d", cap_din.size(), exp_w.size()); end
      for (int k = 0; k < cap_din.size() && k < exp_w.size(); k++) begin
         total++;
         if (cap_din[k] !== exp_w[k] || cap_addr[k] !== AW'(k)) begin
            bad++;
            $display("FAIL stall_word[%0d]: got %h@%h need %h@%h", k, cap_din[k], cap_addr[k], exp_w[k], AW'(k));
         end
      end
   endtask

   task automatic test_overflow();
      bit ok;
      img.delete();
      for (int i = 0; i < 2 * WORDS + 3; i++) img.push_back(8'($urandom));
      build_expected();
      cap_din.delete(); cap_addr.delete();
      req_en = 1'b1; req_pct = 60; req_junk = 1'b0;
      send_image(IDX, 1);
      wait_loaded(20000, ok);
      total++; if (!ok) begin bad++; $display("FAIL ovf_loaded: got %b need 1", bios_loaded); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b need 1", overflow); end
      total++; if (bios_addr !== '0) begin bad++; $display("FAIL ovf_addr: got %h need 0", bios_addr); end
      total++; if (cap_din.size() != WORDS) begin bad++; $display("FAIL ovf_count: got %0d need %0d", cap_din.size(), WORDS); end
      for (int k = 0; k < cap_din.size() && k < exp_w.size(); k++) begin
         total++;
         if (cap_din[k] !== exp_w[k] || cap_addr[k] !== AW'(k)) begin
            bad++;
            $display("FAIL ovf_word[%0d]: got %h@%h need %h@%h", k, cap_din[k], cap_addr[k], exp_w[k], AW'(k));
         end
      end
   endtask

   task automatic test_short_image();
      bit ok;
      logic [7:0]  bytes5 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      logic [15:0] exp3 [3]   = '{16'h2211, 16'h4433, 16'h0055};
      cap_din.delete(); cap_addr.delete();
      req_en = 1'b0; req_junk = 1'b0; req_pct = 100;
      @(negedge clk_sys);
      ioctl_index = IDX;
      ioctl_download = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ioctl_wr = 1'b1;
         ioctl_addr = 25'(i);
         ioctl_dout = bytes5[i];
         @(negedge clk_sys);
         ioctl_wr = 1'b0;
         if (i == 1) begin
            total++; if (bios_wr !== 1'b1) begin bad++; $display("FAIL short_push_wr: got %b need 1", bios_wr); end
            total++; if (bios_din !== 16'h2211) begin bad++; $display("FAIL short_push_din: got %h need 2211", bios_din); end
            total++; if (bios_loaded !== 1'b0) begin bad++; $display("FAIL short_reload_loaded: got %b need 0", bios_loaded); end
            total++; if (overflow !== 1'b0) begin bad++; $display("FAIL short_reload_overflow: got %b need 0", overflow); end
            total++; if (bios_addr !== '0) begin bad++; $display("FAIL short_reload_addr: got %h need 0", bios_addr); end
         end
      end
      ioctl_download = 1'b0;
      repeat (5) @(negedge clk_sys);
      total++; if (bios_loaded !== 1'b0 || bios_din !== 16'h2211) begin
         bad++; $display("FAIL short_held: got loaded=%b din=%h need loaded=0 din=2211", bios_loaded, bios_din);
      end
      req_en = 1'b1;
      wait_loaded(200, ok);
      total++; if (!ok) begin bad++; $display("FAIL short_loaded: got %b need 1", bios_loaded); end
      total++; if (cap_din.size() != 3) begin bad++; $display("FAIL short_count: got %0d need 3", cap_din.size()); end
      for (int k = 0; k < 3 && k < cap_din.size(); k++) begin
         total++;
         if (cap_din[k] !== exp3[k] || cap_addr[k] !== AW'(k)) begin
            bad++;
            $display("FAIL short_word[%0d]: got %h@%h need %h@%h", k, cap_din[k], cap_addr[k], exp3[k], AW'(k));
         end
      end
   endtask

   task automatic test_ignored_and_empty();
      apply_reset();
      img.delete();
      for (int i = 0; i < 10; i++) img.push_back(8'($urandom));
      cap_din.delete(); cap_addr.delete();
      req_en = 1'b1; req_pct = 100; req_junk = 1'b1;
      send_image(8'h01, 0);
      repeat (20) @(negedge clk_sys);
      total++; if (cap_din.size() != 0) begin bad++; $display("FAIL ign_writes: got %0d need 0", cap_din.size()); end
      total++; if (bios_addr !== '0) begin bad++; $display("FAIL ign_addr: got %h need 0", bios_addr); end
      total++; if (bios_loaded !== 1'b0 || core_reset !== 1'b1) begin
         bad++; $display("FAIL ign_status: got loaded=%b core_reset=%b need 0/1", bios_loaded, core_reset);
      end
      img.delete();
      send_image(IDX, 0);
      repeat (20) @(negedge clk_sys);
      total++; if (bios_loaded !== 1'b0) begin bad++; $display("FAIL empty_loaded: got %b need 0", bios_loaded); end
      total++; if (cap_din.size() != 0 || bios_addr !== '0) begin
         bad++; $display("FAIL empty_writes: got %0d writes addr %h need 0/0", cap_din.size(), bios_addr);
      end
      req_junk = 1'b0;
   endtask

   task automatic test_reset_midload();
      bit ok;
      int cr_bad = 0;
      apply_reset();
      img.delete();
      for (int i = 0; i < 2 * WORDS; i++) img.push_back(8'($urandom));
      cap_din.delete(); cap_addr.delete();
      req_en = 1'b1; req_pct = 80;
      fork
         send_image(IDX, 0);
         begin
            int c = 0;
            while (cap_din.size() < 100 && c < 5000) begin
               @(negedge clk_sys);
               c++;
            end
            total++; if (cap_din.size() < 100) begin bad++; $display("FAIL mid_progress: got %0d words need 100", cap_din.size()); end
            abort_tx = 1'b1;
         end
      join
      req_en = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      abort_tx = 1'b0;
      total++; if (bios_addr !== '0 || bios_wr !== 1'b0) begin
         bad++; $display("FAIL mid_reset_port: got addr=%h wr=%b need 0/0", bios_addr, bios_wr);
      end
      total++; if (core_reset !== 1'b1 || bios_loaded !== 1'b0) begin
         bad++; $display("FAIL mid_reset_status: got core_reset=%b loaded=%b need 1/0", core_reset, bios_loaded);
      end
      img.delete();
      for (int i = 0; i < 2 * WORDS; i++) img.push_back(8'($urandom));
      build_expected();
      cap_din.delete(); cap_addr.delete();
      req_en = 1'b1; req_pct = 80;
      fork
         send_image(IDX, 0);
         begin
            int c = 0;
            while (bios_loaded !== 1'b1 && c < 20000) begin
               if (core_reset !== 1'b1) cr_bad++;
               @(negedge clk_sys);
               c++;
            end
         end
      join
      wait_loaded(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL mid_loaded: got %b need 1", bios_loaded); end
      total++; if (cr_bad != 0) begin bad++; $display("FAIL mid_core_reset: got %0d low cycles need 0", cr_bad); end
      total++; if (cap_din.size() != exp_w.size()) begin bad++; $display("FAIL mid_count: got %0d need %0d", cap_din.size(), exp_w.size()); end
      for (int k = 0; k < cap_din.size() && k < exp_w.size(); k++) begin
         total++;
         if (cap_din[k] !== exp_w[k] || cap_addr[k] !== AW'(k)) begin
            bad++;
            $display("FAIL mid_word[%0d]: got %h@%h need %h@%h", k, cap_din[k], cap_addr[k], exp_w[k], AW'(k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_stall();
      test_overflow();
      test_short_image();
      test_ignored_and_empty();
      test_reset_midload();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
